// File: rtl/multimode_reg_pkg.sv
// rtl/multimode_reg_pkg.sv - mode encodings and width constant for multimode_reg
package multimode_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'b011;
  localparam logic [MODE_W-1:0] MODE_INC   = 3'b100;
  localparam logic [MODE_W-1:0] MODE_DEC   = 3'b101;
  localparam logic [MODE_W-1:0] MODE_LFSR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b111;

endpackage

// File: rtl/dff_sync_bank.sv
// rtl/dff_sync_bank.sv - WIDTH-wide D flip-flop bank with synchronous active-high reset
module dff_sync_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/multimode_reg.sv
// rtl/multimode_reg.sv - multimode register: load/shift/count/clear, LFSR step under MULTIMODE_REG_LFSR_EN
module multimode_reg
  import multimode_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out,
  output logic              wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic             ser_next;
  logic             wrap_next;

`ifndef MULTIMODE_REG_LFSR_EN
  wire unused_taps = ^TAPS;
`endif

  always_comb begin
    q_next    = q;
    ser_next  = ser_out;
    wrap_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD: q_next = d;
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], ser_in};
          ser_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next   = {ser_in, q[WIDTH-1:1]};
          ser_next = q[0];
        end
        MODE_INC: begin
          q_next    = q + ONE;
          wrap_next = &q;
        end
        MODE_DEC: begin
          q_next    = q - ONE;
          wrap_next = ~|q;
        end
`ifdef MULTIMODE_REG_LFSR_EN
        MODE_LFSR: begin
          // all-zero is the lock-up state of an XOR LFSR, so seed it with 1
          q_next   = (q == '0) ? ONE : {q[WIDTH-2:0], ^(q & TAPS)};
          ser_next = q[0];
        end
`endif
        MODE_CLEAR: q_next = RESET_VAL;
        default: ;
      endcase
    end
  end

  dff_sync_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_data_bank (
    .clk   (clk),
    .reset (reset),
    .d     (q_next),
    .q     (q)
  );

  // flag bits reset to zero independently of RESET_VAL
  dff_sync_bank #(
    .WIDTH     (2),
    .RESET_VAL (2'b00)
  ) u_flag_bank (
    .clk   (clk),
    .reset (reset),
    .d     ({ser_next, wrap_next}),
    .q     ({ser_out, wrap})
  );

endmodule

// File: tb/tb_multimode_reg.sv
// tb/tb_multimode_reg.sv - table-driven self-checking bench for multimode_reg (WIDTH=8, MULTIMODE_REG_LFSR_EN optional)
module tb_multimode_reg;
  import multimode_reg_pkg::*;

  logic              clk;
  logic              reset;
  logic              en;
  logic [MODE_W-1:0] mode;
  logic [7:0]        d;
  logic              ser_in;
  logic [7:0]        q;
  logic              ser_out;
  logic              wrap;

  int n_pass = 0;
  int n_total = 0;

  multimode_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00),
    .TAPS      (8'hB8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .ser_in  (ser_in),
    .q       (q),
    .ser_out (ser_out),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [2:0]  mode;
    logic [7:0]  d;
    logic        ser_in;
    logic [7:0]  exp_q;
    logic        exp_ser;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst, input logic e, input logic [2:0] m,
                     input logic [7:0] dd, input logic si, input logic [7:0] eq,
                     input logic es, input logic ew);
    vec_t v;
    v.name = name; v.rst = rst; v.en = e; v.mode = m; v.d = dd; v.ser_in = si;
    v.exp_q = eq; v.exp_ser = es; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic e, input logic [2:0] m,
                      input logic [7:0] dd, input logic si);
    @(negedge clk);
    reset = rst; en = e; mode = m; d = dd; ser_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eq, input logic es, input logic ew);
    n_total++;
    if (q === eq && ser_out === es && wrap === ew) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got q=%h ser_out=%b wrap=%b, expected q=%h ser_out=%b wrap=%b",
               name, q, ser_out, wrap, eq, es, ew);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = MODE_HOLD; d = 8'h00; ser_in = 1'b0;

    add("reset_state",   1, 0, MODE_HOLD,  8'h00, 0, 8'h00, 0, 0);
    add("load_5a",       0, 1, MODE_LOAD,  8'h5A, 0, 8'h5A, 0, 0);
    add("reset_5a",      1, 0, MODE_HOLD,  8'h00, 0, 8'h00, 0, 0);
    add("reset_ovr_ld",  1, 1, MODE_LOAD,  8'hFF, 0, 8'h00, 0, 0);
    add("load_fe",       0, 1, MODE_LOAD,  8'hFE, 0, 8'hFE, 0, 0);
    add("inc_ff",        0, 1, MODE_INC,   8'h00, 0, 8'hFF, 0, 0);
    add("inc_wrap",      0, 1, MODE_INC,   8'h00, 0, 8'h00, 0, 1);
    add("wrap_one_cyc",  0, 1, MODE_HOLD,  8'h00, 0, 8'h00, 0, 0);
    add("dec_wrap",      0, 1, MODE_DEC,   8'h00, 0, 8'hFF, 0, 1);
    add("dec_fe",        0, 1, MODE_DEC,   8'h00, 0, 8'hFE, 0, 0);
    add("load_81",       0, 1, MODE_LOAD,  8'h81, 0, 8'h81, 0, 0);
    add("shl_0",         0, 1, MODE_SHL,   8'h00, 0, 8'h02, 1, 0);
    add("shr_1",         0, 1, MODE_SHR,   8'h00, 1, 8'h81, 0, 0);
    add("shr_0",         0, 1, MODE_SHR,   8'h00, 0, 8'h40, 1, 0);
    add("load_10",       0, 1, MODE_LOAD,  8'h10, 0, 8'h10, 1, 0);
    for (int i = 0; i < 5; i++)
      add($sformatf("en0_inc_%0d", i), 0, 0, MODE_INC, 8'h00, 0, 8'h10, 1, 0);
    add("clear",         0, 1, MODE_CLEAR, 8'h00, 0, 8'h00, 1, 0);
    add("load_ff",       0, 1, MODE_LOAD,  8'hFF, 0, 8'hFF, 1, 0);
    add("en0_no_wrap",   0, 0, MODE_INC,   8'h00, 0, 8'hFF, 1, 0);
    add("load_05",       0, 1, MODE_LOAD,  8'h05, 0, 8'h05, 1, 0);
    add("run_inc_06",    0, 1, MODE_INC,   8'h00, 0, 8'h06, 1, 0);
    add("run_inc_07",    0, 1, MODE_INC,   8'h00, 0, 8'h07, 1, 0);
    add("reset_mid_inc", 1, 1, MODE_INC,   8'h00, 0, 8'h00, 0, 0);
    add("inc_after_rst", 0, 1, MODE_INC,   8'h00, 0, 8'h01, 0, 0);
    add("load_3c",       0, 1, MODE_LOAD,  8'h3C, 0, 8'h3C, 0, 0);
`ifndef MULTIMODE_REG_LFSR_EN
    add("mode110_hold",  0, 1, MODE_LFSR,  8'h00, 1, 8'h3C, 0, 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].ser_in);
      check(vecs[i].name, vecs[i].exp_q, vecs[i].exp_ser, vecs[i].exp_wrap);
    end

    // shift run of ones interrupted by reset, then shift from RESET_VAL
    begin
      logic [7:0] eq;
      logic       es;
      step(0, 1, MODE_CLEAR, 8'h00, 0);
      eq = 8'h00; es = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(0, 1, MODE_SHL, 8'h00, 1);
        es = eq[7];
        eq = {eq[6:0], 1'b1};
        check($sformatf("shl_run_%0d", i), eq, es, 0);
      end
      step(1, 1, MODE_SHL, 8'h00, 1);
      check("reset_mid_shl", 8'h00, 0, 0);
      step(0, 1, MODE_SHR, 8'h00, 1);
      check("shr_after_rst", 8'h80, 0, 0);
    end

`ifdef MULTIMODE_REG_LFSR_EN
    begin
      logic [7:0] eq;
      logic       es;
      bit         seen [256];
      int         repeats;
      step(0, 1, MODE_CLEAR, 8'h00, 0);
      step(0, 1, MODE_LFSR, 8'h00, 0);
      check("lfsr_escape", 8'h01, 0, 0);
      eq = 8'h01; es = 1'b0; repeats = 0;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      seen[1] = 1'b1;
      for (int i = 0; i < 255; i++) begin
        step(0, 1, MODE_LFSR, 8'h00, 0);
        es = eq[0];
        eq = {eq[6:0], eq[7] ^ eq[5] ^ eq[4] ^ eq[3]};
        if (i < 254 && seen[q]) repeats++;
        if (q < 256) seen[q] = 1'b1;
        if (q !== eq || ser_out !== es) check($sformatf("lfsr_step_%0d", i), eq, es, 0);
      end
      check("lfsr_period", 8'h01, es, 0);
      n_total++;
      if (repeats == 0) n_pass++;
      else $display("FAIL lfsr_no_repeat: got %0d repeats, expected 0", repeats);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
